pixel_word_serializer: RTL and testbench

Parallel-to-serial readout stage built on the team's D flip-flop cells. It accepts a WIDTH-bit word through a valid/ready handshake and shifts it out MSB first, one bit per enabled clock. Downstream logic can stall the stream with `shift_en`. The block sits directly downstream of the flip-flop register that holds the captured pixel or ADC word, and it feeds the serial readout link.

---
 rtl/pixel_word_serializer.sv | 99 +++++++++
 tb/tb_pixel_word_serializer.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_word_serializer.sv
// pixel_word_serializer
// Parallel-to-serial readout stage: accepts a WIDTH-bit word via valid/ready
// and shifts it out MSB first, one bit per clock with shift_en high.
// All outputs decode from registered state only (no input-to-output paths).
module pixel_word_serializer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             first_bit,
  output logic             done
);

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sreg_q, sreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             first_q, first_d;

  // State register with asynchronous reset; a mid-word reset discards the word.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours, regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sreg_q  <= '0;
      cnt_q   <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sreg_q  <= sreg_d;
      cnt_q   <= cnt_d;
      first_q <= first_d;
    end
  end

  // Next-state logic: load in IDLE, shift or exit in SHIFT, one-cycle DONE.
  // NOTE: every signal gets a hold default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    sreg_d  = sreg_q;
    cnt_d   = cnt_q;
    first_d = first_q;
    unique case (state_q)
      IDLE: begin
        if (load_valid) begin
          sreg_d  = load_data;
          cnt_d   = CW'(WIDTH - 1);
          first_d = 1'b1;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Stalls (shift_en low) hold everything, keeping ser_out stable.
        if (shift_en) begin
          if (cnt_q != '0) begin
            sreg_d  = {sreg_q[WIDTH-2:0], 1'b0};
            cnt_d   = cnt_q - 1'b1;
            first_d = 1'b0;
          end else begin
            // Exit at cnt==0, so the counter never wraps.
            sreg_d  = '0;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Output decode from registered state only.
  always_comb begin
    load_ready = (state_q == IDLE);
    ser_valid  = (state_q == SHIFT);
    ser_out    = (state_q == SHIFT) & sreg_q[WIDTH-1];
    first_bit  = (state_q == SHIFT) & first_q;
    done       = (state_q == DONE);
  end

endmodule

// File: tb/tb_pixel_word_serializer.sv
// Testbench for pixel_word_serializer: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// word/bit-position model of the serializer.
module tb_pixel_word_serializer;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             load_valid = 1'b0;
  logic [WIDTH-1:0] load_data = '0;
  logic             shift_en = 1'b0;
  logic             load_ready, ser_out, ser_valid, first_bit, done;

  int n_checks = 0;
  int n_pass   = 0;

  pixel_word_serializer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .shift_en   (shift_en),
    .ser_out    (ser_out),
    .ser_valid  (ser_valid),
    .first_bit  (first_bit),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the word held and how many of its bits have been consumed.
  // m_pos = -1 idle, 0..WIDTH-1 bits consumed so far, WIDTH = done pulse cycle.
  logic [WIDTH-1:0] m_word = '0;
  int               m_pos  = -1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pos  <= -1;
      m_word <= '0;
    end else if (m_pos == -1) begin
      if (load_valid) begin
        m_word <= load_data;
        m_pos  <= 0;
      end
    end else if (m_pos == WIDTH) begin
      m_pos <= -1;
    end else if (shift_en) begin
      m_pos <= m_pos + 1;
    end
  end

  // Compare process: all outputs against the model, mid-cycle.
  always @(negedge clk) begin
    logic       e_valid, e_out, e_first, e_done, e_ready;
    e_valid = (m_pos >= 0) && (m_pos < WIDTH);
    e_out   = e_valid ? m_word[WIDTH-1-m_pos] : 1'b0;
    e_first = (m_pos == 0);
    e_done  = (m_pos == WIDTH);
    e_ready = (m_pos == -1);
    check("model_cycle", {27'd0, load_ready, ser_valid, ser_out, first_bit, done},
          {27'd0, e_ready, e_valid, e_out, e_first, e_done});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Load one word then consume it, optionally stalling and pulsing a busy load.
  task automatic run_word(input logic [WIDTH-1:0] d, input int stall_at, input int stall_len,
                          input int busy_at, output logic [WIDTH-1:0] bits,
                          output int done_cyc, output int first_cnt, output logic held_or);
    int nb;
    int stalls;
    nb = 0; stalls = 0; bits = '0; done_cyc = -1; first_cnt = 0; held_or = 1'b0;
    load_data  = d;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    step();
    load_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (nb == stall_at && stalls < stall_len) begin
        shift_en = 1'b0;
        stalls++;
        held_or = held_or | ser_out;
      end else begin
        shift_en = 1'b1;
      end
      if (c == busy_at) begin
        load_valid = 1'b1;
        load_data  = '1;
        check("busy_ready_low", {31'd0, load_ready}, 32'd0);
      end else if (c == busy_at + 1) begin
        load_valid = 1'b0;
      end
      if (first_bit) first_cnt++;
      if (ser_valid && shift_en) begin
        bits = {bits[WIDTH-2:0], ser_out};
        nb++;
      end
      if (done) begin
        done_cyc = c;
        break;
      end
      step();
    end
    load_valid = 1'b0;
  endtask

  initial begin
    logic [WIDTH-1:0] bits;
    int               dcyc, fcnt;
    logic             hor;
    logic [19:0]      vv, oo;
    logic             saw_done;

    // Reset state.
    #1;
    check("reset_outputs", {27'd0, load_ready, ser_valid, ser_out, first_bit, done}, 32'h10);
    step();
    step();
    rst_n = 1'b1;
    step();

    // Idle shift: shift_en toggling in IDLE has no effect.
    for (int i = 0; i < 6; i++) begin
      shift_en = i[0];
      step();
      check("idle_shift", {28'd0, load_ready, ser_valid, ser_out, done}, 32'h8);
    end

    // Basic word 0xA5.
    run_word(8'hA5, -1, 0, -1, bits, dcyc, fcnt, hor);
    check("basic_bits", {24'd0, bits}, 32'hA5);
    check("basic_done_cycle", dcyc, 32'd9);
    check("basic_first_count", fcnt, 32'd1);
    step();
    check("basic_ready_cycle10", {31'd0, load_ready}, 32'd1);

    // Stall 3 cycles after 2 bits of 0xC3.
    run_word(8'hC3, 2, 3, -1, bits, dcyc, fcnt, hor);
    check("stall_bits", {24'd0, bits}, 32'hC3);
    check("stall_done_cycle", dcyc, 32'd12);
    check("stall_held_zero", {31'd0, hor}, 32'd0);
    step();

    // Busy load of 0xFF during 0x0F.
    run_word(8'h0F, -1, 0, 3, bits, dcyc, fcnt, hor);
    check("busy_bits", {24'd0, bits}, 32'h0F);
    check("busy_done_cycle", dcyc, 32'd9);
    step();
    check("busy_ready_after", {31'd0, load_ready}, 32'd1);

    // Reset mid-word on 0x96 after 3 bits.
    saw_done   = 1'b0;
    load_data  = 8'h96;
    load_valid = 1'b1;
    shift_en   = 1'b1;
    step();
    load_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      saw_done = saw_done | done;
      step();
    end
    check("midword_valid", {31'd0, ser_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {27'd0, load_ready, ser_valid, ser_out, first_bit, done}, 32'h10);
    for (int i = 0; i < 3; i++) begin
      step();
      saw_done = saw_done | done;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      saw_done = saw_done | done;
    end
    check("reset_no_done", {31'd0, saw_done}, 32'd0);
    run_word(8'h01, -1, 0, -1, bits, dcyc, fcnt, hor);
    check("post_reset_bits", {24'd0, bits}, 32'h01);
    check("post_reset_done_cycle", dcyc, 32'd9);
    step();

    // Back-to-back: 0xFF then 0x00 with load_valid held.
    load_valid = 1'b1;
    load_data  = 8'hFF;
    shift_en   = 1'b1;
    vv = '0;
    oo = '0;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c == 1) load_data = 8'h00;
      if (c == 11) load_valid = 1'b0;
      vv[c-1] = ser_valid;
      oo[c-1] = ser_out;
    end
    check("b2b_valid_pattern", {12'd0, vv}, 32'h3FCFF);
    check("b2b_out_pattern", {12'd0, oo}, 32'h000FF);

    // Randomized traffic with occasional asynchronous resets.
    for (int i = 0; i < 3000; i++) begin
      load_valid = ($urandom_range(0, 1) == 1);
      load_data  = WIDTH'($urandom);
      shift_en   = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 199) == 0) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end
      step();
    end

    load_valid = 1'b0;
    shift_en   = 1'b0;
    step();
    step();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
